// File: rtl/bpm_pkg.sv
// Shared types and defaults for the heart-rate meter: FSM encoding,
// default widths, and the dividend-width helper.
package bpm_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DIV  = 2'd1,
    DONE = 2'd2
  } bpm_state_t;

  localparam int PD_W_DEF  = 8;
  localparam int BPM_W_DEF = 8;
  localparam int NUMER_DEF = 6000;

  // Number of quotient bits, and therefore divide cycles, for a given dividend.
  function automatic int div_width(input int numer);
    return $clog2(numer + 1);
  endfunction

endpackage

// File: rtl/seq_divider.sv
// Multi-cycle restoring divider: one quotient bit per cycle, NW cycles per
// division. done_o and quot_o are valid together in the final step cycle.
module seq_divider #(
  parameter int NW = 13,
  parameter int DW = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start_i,
  input  logic [NW-1:0] dividend_i,
  input  logic [DW-1:0] divisor_i,
  output logic          done_o,
  output logic [NW-1:0] quot_o
);

  localparam int SW = $clog2(NW + 1);

  logic [NW-1:0] quo_q, quo_d;
  logic [DW-1:0] rem_q, rem_d;
  logic [DW-1:0] dvs_q;
  logic [SW-1:0] step_q;
  logic          run_q;
  logic [DW:0]   shifted;
  logic          ge;

  // The remainder stays below the divisor, so DW bits hold it between steps.
  always_comb begin
    shifted = {rem_q, quo_q[NW-1]};
    ge      = shifted >= {1'b0, dvs_q};
    rem_d   = ge ? DW'(shifted - {1'b0, dvs_q}) : shifted[DW-1:0];
    quo_d   = {quo_q[NW-2:0], ge};
  end

  assign done_o = run_q && (step_q == SW'(NW - 1));
  assign quot_o = quo_d;

  // NOTE: clocked state uses non-blocking assignments so every register
  // samples values from before the edge, regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      quo_q  <= '0;
      rem_q  <= '0;
      dvs_q  <= '0;
      step_q <= '0;
      run_q  <= 1'b0;
    end else if (start_i) begin
      quo_q  <= dividend_i;
      rem_q  <= '0;
      dvs_q  <= divisor_i;
      step_q <= '0;
      run_q  <= 1'b1;
    end else if (run_q) begin
      quo_q  <= quo_d;
      rem_q  <= rem_d;
      step_q <= step_q + 1'b1;
      if (done_o) run_q <= 1'b0;
    end
  end

endmodule

// File: rtl/bpm_meter.sv
// Beat-to-beat period capture and BPM conversion with timeout and a one-entry
// pending buffer. Optional 4-period averaging when BPM_AVG_EN is defined.
module bpm_meter
  import bpm_pkg::*;
#(
  parameter int PD_W  = PD_W_DEF,
  parameter int BPM_W = BPM_W_DEF,
  parameter int NUMER = NUMER_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             tick,
  input  logic             beat,
  output logic [PD_W-1:0]  pd,
  output logic [BPM_W-1:0] bpm,
  output logic             bpm_valid,
  output logic             busy
);

  localparam int NW = div_width(NUMER);
  localparam int QW = (NW > BPM_W) ? NW : BPM_W;
  localparam logic [PD_W-1:0]  CNT_MAX  = '1;
  localparam logic [BPM_W-1:0] BPM_MAX  = '1;
  localparam logic [NW-1:0]    DIVIDEND = NW'(NUMER);

  bpm_state_t       state_q, state_d;
  logic [PD_W-1:0]  cnt_q, cnt_d;
  logic [PD_W-1:0]  pd_q, pd_d;
  logic [PD_W-1:0]  pend_prd_q, pend_prd_d;
  logic [BPM_W-1:0] bpm_q, bpm_d;
  logic             armed_q, armed_d;
  logic             pend_q, pend_d;
  logic             timeout_q, timeout_d;
  logic             valid_q, valid_d;
  logic             div_zero_q, div_zero_d;

  logic             capture, timeout_hit;
  logic [PD_W-1:0]  new_div;
  logic             div_start, div_done;
  logic [NW-1:0]    div_quot;
  logic [QW-1:0]    quot_ext;

  assign capture     = beat && armed_q;
  assign timeout_hit = armed_q && !beat && (cnt_q == CNT_MAX);

  always_comb begin
    cnt_d = cnt_q;
    if (beat)                          cnt_d = tick ? PD_W'(1) : '0;
    else if (tick && cnt_q != CNT_MAX) cnt_d = cnt_q + 1'b1;
    armed_d = beat ? 1'b1 : (timeout_hit ? 1'b0 : armed_q);
    pd_d    = capture ? cnt_q : pd_q;
  end

`ifdef BPM_AVG_EN
  localparam int SUM_W = PD_W + 2;

  logic [PD_W-1:0]  hist_q [4];
  logic [PD_W-1:0]  hist_d [4];
  logic             hist_vld_q, hist_vld_d;
  logic [SUM_W-1:0] sum;

  always_comb begin
    sum = hist_vld_q ? SUM_W'(cnt_q) + SUM_W'(hist_q[0]) + SUM_W'(hist_q[1]) + SUM_W'(hist_q[2])
                     : {cnt_q, 2'b00};
    new_div    = PD_W'(sum >> 2);
    hist_d     = hist_q;
    hist_vld_d = hist_vld_q;
    if (timeout_hit) begin
      for (int i = 0; i < 4; i++) hist_d[i] = '0;
      hist_vld_d = 1'b0;
    end else if (capture) begin
      if (hist_vld_q) hist_d = '{cnt_q, hist_q[0], hist_q[1], hist_q[2]};
      else for (int i = 0; i < 4; i++) hist_d[i] = cnt_q;
      hist_vld_d = 1'b1;
    end
  end

  // NOTE: the history array is reset explicitly; it feeds the divisor sum
  // and must never contribute stale or X values after reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 4; i++) hist_q[i] <= '0;
      hist_vld_q <= 1'b0;
    end else begin
      hist_q     <= hist_d;
      hist_vld_q <= hist_vld_d;
    end
  end
`else
  assign new_div = cnt_q;
`endif

  seq_divider #(.NW(NW), .DW(PD_W)) u_div (
    .clk        (clk),
    .rst        (rst),
    .start_i    (div_start),
    .dividend_i (DIVIDEND),
    .divisor_i  (pend_prd_q),
    .done_o     (div_done),
    .quot_o     (div_quot)
  );

  assign quot_ext = QW'(div_quot);

  // NOTE: every signal written here gets a default first, so no path
  // through the case can leave one unassigned and infer a latch.
  always_comb begin
    state_d    = state_q;
    pend_d     = pend_q;
    pend_prd_d = pend_prd_q;
    timeout_d  = timeout_q | timeout_hit;
    bpm_d      = bpm_q;
    valid_d    = 1'b0;
    div_start  = 1'b0;
    div_zero_d = div_zero_q;
    unique case (state_q)
      IDLE: begin
        if (pend_q) begin
          div_start  = 1'b1;
          pend_d     = 1'b0;
          div_zero_d = (pend_prd_q == '0);
          state_d    = DIV;
        end else if (timeout_q) begin
          bpm_d     = '0;
          valid_d   = 1'b1;
          timeout_d = timeout_hit;
        end
      end
      DIV: begin
        if (div_done) begin
          bpm_d   = (div_zero_q || quot_ext > QW'(BPM_MAX)) ? BPM_MAX : quot_ext[BPM_W-1:0];
          valid_d = 1'b1;
          state_d = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    // A beat landing in the load cycle stays pending for the next division.
    if (capture) begin
      pend_d     = 1'b1;
      pend_prd_d = new_div;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      pd_q       <= '0;
      pend_prd_q <= '0;
      bpm_q      <= '0;
      armed_q    <= 1'b0;
      pend_q     <= 1'b0;
      timeout_q  <= 1'b0;
      valid_q    <= 1'b0;
      div_zero_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      pd_q       <= pd_d;
      pend_prd_q <= pend_prd_d;
      bpm_q      <= bpm_d;
      armed_q    <= armed_d;
      pend_q     <= pend_d;
      timeout_q  <= timeout_d;
      valid_q    <= valid_d;
      div_zero_q <= div_zero_d;
    end
  end

  assign pd        = pd_q;
  assign bpm       = bpm_q;
  assign bpm_valid = valid_q;
  assign busy      = (state_q != IDLE) || pend_q || timeout_q;

endmodule

// File: tb/tb_bpm_meter.sv
// Directed bench for bpm_meter: period capture, latency, saturation,
// timeout, pending overwrite, mid-division reset, and averaging when enabled.
module tb_bpm_meter;

  logic       clk = 1'b0;
  logic       rst, tick, beat;
  logic [7:0] pd, bpm;
  logic       bpm_valid, busy;

  bpm_meter dut (
    .clk       (clk),
    .rst       (rst),
    .tick      (tick),
    .beat      (beat),
    .pd        (pd),
    .bpm       (bpm),
    .bpm_valid (bpm_valid),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_errors = 0;
  int last_beat = 0;
  int vq_bpm[$];
  int vq_cyc[$];
  int consec = 0;
  bit prev_v = 1'b0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Record every result pulse with its cycle; flag back-to-back pulses.
  always @(negedge clk) begin
    if (bpm_valid === 1'b1) begin
      vq_bpm.push_back(int'(bpm));
      vq_cyc.push_back(cyc);
      if (prev_v) consec++;
    end
    prev_v = (bpm_valid === 1'b1);
  end

  task automatic next();
    @(posedge clk);
    #1;
  endtask

  task automatic run_to(input int c);
    while (cyc < c) next();
  endtask

  task automatic pulse_beat();
    beat = 1'b1;
    last_beat = cyc;
    next();
    beat = 1'b0;
  endtask

  task automatic beat_at(input int interval);
    run_to(last_beat + interval);
    pulse_beat();
  endtask

  task automatic expect_valid(input string tag, input int exp_bpm, input int exp_lat);
    int w = 0;
    while (vq_bpm.size() == 0 && w < 500) begin
      next();
      w++;
    end
    check({tag, "_seen"}, vq_bpm.size() > 0, 1);
    if (vq_bpm.size() > 0) begin
      check(tag, vq_bpm.pop_front(), exp_bpm);
      if (exp_lat >= 0) check({tag, "_lat"}, vq_cyc.pop_front() - last_beat, exp_lat);
      else void'(vq_cyc.pop_front());
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; tick = 1'b0; beat = 1'b0;
    repeat (3) next();
    check("rst_pd", pd, 0);
    check("rst_bpm", bpm, 0);
    check("rst_valid", bpm_valid, 0);
    check("rst_busy", busy, 0);
    rst = 1'b0;
    tick = 1'b1;
    next();

`ifdef BPM_AVG_EN
    pulse_beat();
    beat_at(100); check("avg1_pd", pd, 100); expect_valid("avg1", 60, 15);
    beat_at(100); check("avg2_pd", pd, 100); expect_valid("avg2", 60, 15);
    beat_at(100); check("avg3_pd", pd, 100); expect_valid("avg3", 60, 15);
    beat_at(60);  check("avg4_pd", pd, 60);  expect_valid("avg4", 66, 15);
`else
    // First beat only arms.
    pulse_beat();
    next();
    check("arm_pd", pd, 0);
    check("arm_busy", busy, 0);

    beat_at(100); check("p100_pd", pd, 100); expect_valid("p100", 60, 15);
    beat_at(75);  check("p75_pd", pd, 75);   expect_valid("p75", 80, 15);
    beat_at(23);  check("p23_pd", pd, 23);   expect_valid("p23", 255, 15);
    beat_at(24);  check("p24_pd", pd, 24);   expect_valid("p24", 250, 15);

    // Beat with no tick restarts the counter at 0; next beat with no ticks gives pd=0.
    run_to(last_beat + 40);
    tick = 1'b0;
    pulse_beat(); check("p40_pd", pd, 40);   expect_valid("p40", 150, 15);
    beat_at(20);  check("p0_pd", pd, 0);     expect_valid("p0", 255, 15);

    // Armed with no further beat: timeout reports a zero.
    tick = 1'b1;
    expect_valid("timeout", 0, -1);
    next();
    check("timeout_busy", busy, 0);
    check("timeout_pd", pd, 0);

    // After timeout the next beat re-arms only.
    pulse_beat();
    repeat (30) next();
    check("rearm_no_result", vq_bpm.size(), 0);
    check("rearm_pd", pd, 0);
    beat_at(50); check("p50_pd", pd, 50); expect_valid("p50", 120, 15);

    // Three beats two cycles apart: middle period is overwritten.
    beat_at(50); check("b1_pd", pd, 50);
    beat_at(2);  check("b2_pd", pd, 2);
    beat_at(2);  check("b3_pd", pd, 2);
    repeat (40) next();
    check("burst_count", vq_bpm.size(), 2);
    if (vq_bpm.size() == 2) begin
      check("burst_first", vq_bpm.pop_front(), 120);
      check("burst_last", vq_bpm.pop_front(), 255);
      void'(vq_cyc.pop_front());
      void'(vq_cyc.pop_front());
    end

    // Reset in the fifth DIV cycle aborts everything.
    beat_at(60); check("p60_pd", pd, 60);
    run_to(last_beat + 6);
    rst = 1'b1;
    #1;
    check("midrst_pd", pd, 0);
    check("midrst_bpm", bpm, 0);
    check("midrst_valid", bpm_valid, 0);
    check("midrst_busy", busy, 0);
    next(); next();
    rst = 1'b0;
    repeat (20) next();
    check("midrst_no_result", vq_bpm.size(), 0);
    pulse_beat();
    repeat (20) next();
    check("postrst_arm_only", vq_bpm.size(), 0);
    check("postrst_pd", pd, 0);
    beat_at(100); check("postrst_pd100", pd, 100); expect_valid("postrst", 60, 15);
`endif

    repeat (5) next();
    check("no_back_to_back", consec, 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
